// File: rtl/rf_bypass_param.sv
// Parametrised register file with a one-entry write-commit stage and two-level read bypass.
// Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module rf_bypass_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int NREAD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    readregsel,
  output logic [NREAD*WIDTH-1:0] readdata,
  input  logic                   write,
  input  logic [AW-1:0]          writeregsel,
  input  logic [WIDTH-1:0]       writedata,
  output logic                   err,
  output logic                   stage_valid
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic             stg_v;
  logic [AW-1:0]    stg_sel;
  logic [WIDTH-1:0] stg_data;
  logic             err_q;
  logic             wr_ok;
  logic             stage_load;
  logic             rd_oob;
  logic [AW-1:0]    sel;
  logic [WIDTH-1:0] rd;

  function automatic logic in_range(input logic [AW-1:0] s);
    return {1'b0, s} < DEPTH_LIM;
  endfunction

  // A write to the hardwired zero register is accepted but never occupies the stage.
  always_comb begin
    wr_ok      = write && in_range(writeregsel);
    stage_load = wr_ok && !(ZERO_REG && (writeregsel == '0));
    rd_oob     = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (!in_range(readregsel[i*AW +: AW])) rd_oob = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      stg_v    <= 1'b0;
      stg_sel  <= '0;
      stg_data <= '0;
      err_q    <= 1'b0;
    end else begin
      if (stg_v) mem[stg_sel] <= stg_data;
      stg_v <= stage_load;
      if (stage_load) begin
        stg_sel  <= writeregsel;
        stg_data <= writedata;
      end
      if ((write && !in_range(writeregsel)) || rd_oob) err_q <= 1'b1;
    end
  end

  // Newest value wins: incoming write, then staged write, then the array.
  always_comb begin
    readdata = '0;
    sel      = '0;
    rd       = '0;
    for (int i = 0; i < NREAD; i++) begin
      sel = readregsel[i*AW +: AW];
      rd  = '0;
      if (!rst && in_range(sel) && !(ZERO_REG && (sel == '0))) begin
        if (wr_ok && (writeregsel == sel))
          rd = writedata;
        else if (stg_v && (stg_sel == sel))
          rd = stg_data;
        else
          rd = mem[sel];
      end
      readdata[i*WIDTH +: WIDTH] = rd;
    end
  end

  assign err         = err_q & ~rst;
  assign stage_valid = stg_v;

endmodule

// File: tb/tb_rf_bypass_param.sv
// Self-checking bench for rf_bypass_param: directed vector table, corner sequences and
// randomized traffic against an architectural model (honours RF_ZERO_REG_EN).
module tb_rf_bypass_param;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  readregsel;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [31:0] readdata, readdata2;
  logic        err, err2, stage_valid, stage_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_bypass_param #(.WIDTH(16), .DEPTH(8), .AW(3), .NREAD(2)) dut (
    .clk(clk), .rst(rst), .readregsel(readregsel), .readdata(readdata),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .err(err), .stage_valid(stage_valid));

  rf_bypass_param #(.WIDTH(16), .DEPTH(6), .AW(3), .NREAD(2)) dut6 (
    .clk(clk), .rst(rst), .readregsel(readregsel), .readdata(readdata2),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .err(err2), .stage_valid(stage_valid2));

  typedef struct {
    logic        rst;
    logic        wr;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        esv;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic w, logic [2:0] ws, logic [15:0] wd,
                              logic [2:0] a, logic [2:0] b,
                              logic [15:0] ea, logic [15:0] eb, logic sv);
    vec_t v;
    v.rst = r; v.wr = w; v.wsel = ws; v.wdata = wd; v.s0 = a; v.s1 = b;
    v.e0 = ea; v.e1 = eb; v.esv = sv;
    return v;
  endfunction

  // Inputs change after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(logic r, logic w, logic [2:0] ws, logic [15:0] wd,
                               logic [2:0] a, logic [2:0] b);
    @(negedge clk);
    rst = r; write = w; writeregsel = ws; writedata = wd;
    readregsel = {b, a};
    #1;
  endtask

  task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    checkOutput("rst_rd0", readdata[15:0], 16'h0);
    checkOutput("rst_err", {15'b0, err}, 16'h0);
  endtask

  logic [15:0] arch [8];
  logic        sv_m;
  logic [15:0] x0, x1;
  logic        r_r, r_w;
  logic [2:0]  r_ws, r_a, r_b;
  logic [15:0] r_wd;

  function automatic logic [15:0] modelRead(logic [2:0] s);
    if (rst) return 16'h0;
    if (ZR && s == 3'd0) return 16'h0;
    if (write && writeregsel == s) return writedata;
    return arch[s];
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 2, 3, 16'h0000, 16'h0000, 0);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 4, 5, 16'h0000, 16'h0000, 0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 6, 7, 16'h0000, 16'h0000, 0);
    tbl[4]  = mk(0, 1, 3, 16'hBEEF, 3, 4, 16'hBEEF, 16'h0000, 0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 3, 16'h0000, 16'hBEEF, 1);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 3, 3, 16'hBEEF, 16'hBEEF, 0);
    tbl[7]  = mk(0, 1, 5, 16'h1111, 5, 5, 16'h1111, 16'h1111, 0);
    tbl[8]  = mk(0, 1, 5, 16'h2222, 5, 3, 16'h2222, 16'hBEEF, 1);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 5, 5, 16'h2222, 16'h2222, 1);
    tbl[10] = mk(0, 0, 0, 16'h0000, 5, 5, 16'h2222, 16'h2222, 0);
    tbl[11] = mk(0, 1, 2, 16'hAAAA, 2, 2, 16'hAAAA, 16'hAAAA, 0);
    tbl[12] = mk(1, 1, 2, 16'h5555, 2, 2, 16'h0000, 16'h0000, 1);
    tbl[13] = mk(0, 0, 0, 16'h0000, 2, 5, 16'h0000, 16'h0000, 0);
    tbl[14] = mk(0, 1, 7, 16'hFFFF, 7, 6, 16'hFFFF, 16'h0000, 0);
    tbl[15] = mk(0, 1, 6, 16'h0001, 7, 6, 16'hFFFF, 16'h0001, 1);
    tbl[16] = mk(0, 0, 0, 16'h0000, 6, 7, 16'h0001, 16'hFFFF, 1);
    tbl[17] = mk(0, 0, 0, 16'h0000, 6, 7, 16'h0001, 16'hFFFF, 0);

    rst = 1'b1; write = 1'b0; writeregsel = '0; writedata = '0; readregsel = '0;
    doReset();
    checkOutput("rst_sv", {15'b0, stage_valid}, 16'h0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].wr, tbl[i].wsel, tbl[i].wdata, tbl[i].s0, tbl[i].s1);
      checkOutput($sformatf("vec%0d_p0", i), readdata[15:0], tbl[i].e0);
      checkOutput($sformatf("vec%0d_p1", i), readdata[31:16], tbl[i].e1);
      checkOutput($sformatf("vec%0d_sv", i), {15'b0, stage_valid}, {15'b0, tbl[i].esv});
      checkOutput($sformatf("vec%0d_err", i), {15'b0, err}, 16'h0);
    end

    // Register 0 write with simultaneous reads through both bypass levels and the array.
    doReset();
    applyStimulus(0, 1, 3'd0, 16'h1234, 3'd0, 3'd0);
    checkOutput("zr_l1_p0", readdata[15:0], ZR ? 16'h0 : 16'h1234);
    checkOutput("zr_l1_p1", readdata[31:16], ZR ? 16'h0 : 16'h1234);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd0, 3'd0);
    checkOutput("zr_l2_sv", {15'b0, stage_valid}, ZR ? 16'h0 : 16'h1);
    checkOutput("zr_l2_p0", readdata[15:0], ZR ? 16'h0 : 16'h1234);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd0, 3'd0);
    checkOutput("zr_arr_p1", readdata[31:16], ZR ? 16'h0 : 16'h1234);
    checkOutput("zr_arr_sv", {15'b0, stage_valid}, 16'h0);

    // Six-entry instance: out-of-range write and read raise a sticky err.
    doReset();
    applyStimulus(0, 1, 3'd7, 16'h9999, 3'd7, 3'd6);
    checkOutput("d6_oob_p0", readdata2[15:0], 16'h0);
    checkOutput("d6_oob_p1", readdata2[31:16], 16'h0);
    checkOutput("d6_err_pre", {15'b0, err2}, 16'h0);
    checkOutput("d6_sv_pre", {15'b0, stage_valid2}, 16'h0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd1, 3'd5);
    checkOutput("d6_err_set", {15'b0, err2}, 16'h1);
    checkOutput("d6_sv_post", {15'b0, stage_valid2}, 16'h0);
    checkOutput("d6_r5", readdata2[31:16], 16'h0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd6, 3'd1);
    checkOutput("d6_rd6", readdata2[15:0], 16'h0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd1, 3'd2);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd1, 3'd2);
    checkOutput("d6_err_sticky", {15'b0, err2}, 16'h1);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd1, 3'd2);
    checkOutput("d6_err_inrst", {15'b0, err2}, 16'h0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd1, 3'd2);
    checkOutput("d6_err_clr", {15'b0, err2}, 16'h0);

    // Randomized traffic against the architectural model.
    doReset();
    for (int r = 0; r < 8; r++) arch[r] = 16'h0;
    sv_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r_r  = ($urandom_range(0, 31) == 0);
      r_w  = ($urandom_range(0, 2) != 0);
      r_ws = 3'($urandom_range(0, 7));
      r_wd = 16'($urandom);
      r_a  = 3'($urandom_range(0, 7));
      r_b  = ($urandom_range(0, 3) == 0) ? r_ws : 3'($urandom_range(0, 7));
      applyStimulus(r_r, r_w, r_ws, r_wd, r_a, r_b);
      x0 = modelRead(r_a);
      x1 = modelRead(r_b);
      checkOutput("rnd_p0", readdata[15:0], x0);
      checkOutput("rnd_p1", readdata[31:16], x1);
      checkOutput("rnd_sv", {15'b0, stage_valid}, {15'b0, sv_m});
      checkOutput("rnd_err", {15'b0, err}, 16'h0);
      @(posedge clk);
      if (r_r) begin
        for (int r = 0; r < 8; r++) arch[r] = 16'h0;
        sv_m = 1'b0;
      end else begin
        sv_m = r_w && !(ZR && r_ws == 3'd0);
        if (sv_m) arch[r_ws] = r_wd;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_bypass_param.md
Name: rf_bypass_param

Overview:
- Parametrised successor to the fixed 8x16 bypassed register file. Provides configurable data width, register count and number of read ports.
- Adds a one-entry write-commit stage, so a write reaches the storage array one cycle after it is presented.
- Two-level bypass (incoming write, then staged write) keeps reads architecturally current.
- Sits in the decode stage of the pipelined RISC core, feeding operand muxes; writeback drives the write port.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; 2..256.
- AW, 3, select width in bits; must satisfy 2^AW >= DEPTH.
- NREAD, 2, number of independent read ports; 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- readregsel  in  NREAD*AW  packed read selects; port i uses bits [i*AW +: AW].
- readdata  out  NREAD*WIDTH  packed read data; port i uses bits [i*WIDTH +: WIDTH].
- write  in  1  write request for this cycle.
- writeregsel  in  AW  destination register.
- writedata  in  WIDTH  write data.
- err  out  1  sticky error flag.
- stage_valid  out  1  a staged write is pending commit (debug/verification visibility).

Behaviour:
- Storage: DEPTH x WIDTH array. Commit stage holds {stg_v, stg_sel, stg_data}.
- Reset (rst=1 at an edge):
  - All array entries become 0; stg_v=0; err=0.
  - A write presented in a cycle where rst=1 is discarded.
  - A pending staged write is discarded, not committed.
- Write path, for an accepted write (write=1, rst=0, writeregsel<DEPTH) at edge N:
  - Edge N: stage <= {1, writeregsel, writedata}.
  - Edge N+1: array[stg_sel] <= stg_data.
  - If no new accepted write arrives at edge N+1, stg_v <= 0 at edge N+1.
- Back-to-back writes: each cycle commits the previous stage and loads the new one. Sustained throughput is 1 write/cycle.
- Back-to-back writes to the same register: the older value commits, then the newer value commits one edge later. Bypass always returns the newest value.
- Read path, per port i, combinational with zero latency. Priority order:
  1. write=1 and writeregsel==sel_i and writeregsel<DEPTH: return writedata.
  2. stg_v=1 and stg_sel==sel_i: return stg_data.
  3. Otherwise return array[sel_i].
- Read of an out-of-range select (sel_i >= DEPTH): readdata_i=0 and err sets at the next edge.
- All read ports are independent. Several ports may select the same register, and each returns identical data.
- While rst=1: readdata forced to 0 on all ports and err reads 0.
- err:
  - Sets at an edge (rst=0) when write=1 with writeregsel>=DEPTH, or when any read select >= DEPTH. An out-of-range write is otherwise ignored and does not load the stage.
  - Remains 1 until reset.
  - Cannot fire when DEPTH == 2^AW.
- stage_valid = stg_v. Reset value 0.
- No X propagation: on every cycle after reset, readdata is a defined value.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined: register 0 is hardwired to 0.
  - Writes to select 0 are accepted but never load the stage.
  - Neither bypass level returns data for select 0; reads of select 0 always return 0.
  - err behaviour is unchanged.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then read all 8 regs on both ports -> every readdata=0, err=0, stage_valid=0.
- Write r3=16'hBEEF at cycle N with port0 sel=3 the same cycle -> port0=BEEF in cycle N (level-1 bypass). Cycle N+1: stage_valid=1, port1 sel=3 -> BEEF (level-2 bypass). Cycle N+2: stage_valid=0, array path -> BEEF.
- Back-to-back writes r5=0x1111 then r5=0x2222, read r5 each cycle -> 1111, 2222, 2222, 2222. Array holds 2222 after the commit edge.
- Write r2=0xAAAA with rst asserted in the following cycle (stage pending) -> after reset, r2 reads 0 and stage_valid=0.
- Parameterise DEPTH=6, AW=3; write to sel 7 -> no register changes, err=1 next cycle and stays 1 until rst. Read sel 6 -> 0.
- RF_ZERO_REG_EN defined, write r0=0x1234 with simultaneous read of r0 -> 0 on both levels and after commit. The same stimulus without the macro -> 0x1234.
